// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants and types for the frame-memory RAM arbiter.
package ram_access_arbiter_pkg;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int RAM_WORDS = 307200;
  localparam int ROM_WORDS = 76800;
  localparam int READ_LAT  = 2;
  localparam int MAX_WAIT  = 15;
  localparam int STARVE_W  = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    WAIT_INIT = 1'b0,
    RUN       = 1'b1
  } arb_state_t;

  // One entry per granted read: port 0 = display, port 1 = engine.
  typedef struct packed {
    logic valid;
    logic port;
    logic zero;
  } rd_tag_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < RAM_WORDS;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rd_tag_pipe.sv
// Read-tag delay line matching the RAM read latency; flush empties every stage.
module rd_tag_pipe
  import ram_access_arbiter_pkg::*;
#(
  parameter int DEPTH = READ_LAT
) (
  input  logic    clock,
  input  logic    flush,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-port arbiter for the frame-memory RAM: display reads win unless the engine
// has been starved MAX_WAIT cycles; read responses are routed back by tag.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              init_done,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              addr_err
);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   p0_rdata_q;
  logic [DATA_W-1:0]   p1_rdata_q;
  logic                run_en;
  logic                p1_forced;
  logic                gnt_in_range;
  logic [DATA_W-1:0]   rd_value;
  rd_tag_t             tag_in;
  rd_tag_t             tag_out;

  // Grants open in the very cycle init_done first rises, not one cycle later.
  assign run_en    = !reset && (state == RUN || init_done);
  assign p1_forced = p1_req && (starve_cnt == STARVE_W'(MAX_WAIT));
  assign p0_gnt    = run_en && p0_req && !p1_forced;
  assign p1_gnt    = run_en && p1_req && !p0_gnt;

  assign gnt_in_range = p0_gnt ? addr_in_range(p0_addr) : addr_in_range(p1_addr);
  assign mem_we       = p1_gnt && p1_we && addr_in_range(p1_addr);

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (p0_gnt) begin
      mem_addr  = p0_addr;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = p0_gnt || (p1_gnt && !p1_we);
    tag_in.port  = p1_gnt;
    tag_in.zero  = !gnt_in_range;
  end

  rd_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_rd_tag_pipe (
    .clock   (clock),
    .flush   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rd_value  = tag_out.zero ? '0 : mem_q;
  assign p0_rvalid = !reset && tag_out.valid && !tag_out.port;
  assign p1_rvalid = !reset && tag_out.valid && tag_out.port;
  assign p0_rdata  = p0_rvalid ? rd_value : p0_rdata_q;
  assign p1_rdata  = p1_rvalid ? rd_value : p1_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT_INIT;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      addr_err   <= 1'b0;
    end else begin
      if (state == WAIT_INIT && init_done) state <= RUN;
      // Waiting before init is not starvation: the counter only runs once grants can issue.
      if (run_en && p1_req && !p1_gnt) begin
        if (starve_cnt != STARVE_W'(MAX_WAIT)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (p0_rvalid) p0_rdata_q <= p0_rdata;
      if (p1_rvalid) p1_rdata_q <= p1_rdata;
      if ((p0_gnt || p1_gnt) && !gnt_in_range) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: RAM model, rule-based scoreboard and directed scenarios.
module tb_ram_access_arbiter;
  import ram_access_arbiter_pkg::*;

  logic              clock = 1'b0;
  logic              reset, init_done;
  logic              p0_req, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
  logic [DATA_W-1:0] p1_wdata, mem_wdata, mem_q, p0_rdata, p1_rdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_access_arbiter dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q), .addr_err(addr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_byte(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  // Memory block: contents after the ROM copy, two-cycle read latency.
  logic [7:0] ram     [RAM_WORDS];
  logic [7:0] mdl_mem [RAM_WORDS];
  logic [7:0] r1, r2;

  initial begin
    for (int a = 0; a < RAM_WORDS; a++) begin
      ram[a]     = (a < ROM_WORDS) ? rom_byte(a) : 8'h00;
      mdl_mem[a] = (a < ROM_WORDS) ? rom_byte(a) : 8'h00;
    end
  end

  always @(posedge clock) begin
    r1 <= (mem_addr < RAM_WORDS) ? ram[mem_addr] : 8'hEE;
    r2 <= r1;
    if (mem_we && mem_addr < RAM_WORDS) ram[mem_addr] <= mem_wdata;
  end
  assign mem_q = r2;

  // Scoreboard: expected outputs from the arbitration rules plus a response queue.
  typedef struct {
    int         due;
    bit         port;
    logic [7:0] data;
  } resp_t;

  resp_t             pend[$];
  bit                m_run, m_err;
  int                m_starve, cyc;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata, m_rd0, m_rd1;

  always @(negedge clock) begin
    bit                run, force1, e_g0, e_g1, e_we, e_rv0, e_rv1, head;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wd, e_rd0, e_rd1, d;
    cyc++;
    if (reset) begin
      m_run = 0; m_err = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      pend.delete();
    end else begin
      run    = m_run || init_done;
      force1 = p1_req && (m_starve >= MAX_WAIT);
      e_g1   = run && p1_req && (force1 || !p0_req);
      e_g0   = run && p0_req && !e_g1;
      e_addr = e_g0 ? p0_addr : (e_g1 ? p1_addr : m_addr);
      e_wd   = e_g1 ? p1_wdata : m_wdata;
      e_we   = e_g1 && p1_we && (p1_addr < RAM_WORDS);
      head   = (pend.size() > 0) && (pend[0].due == cyc);
      e_rv0  = head && (pend[0].port == 1'b0);
      e_rv1  = head && (pend[0].port == 1'b1);
      e_rd0  = e_rv0 ? pend[0].data : m_rd0;
      e_rd1  = e_rv1 ? pend[0].data : m_rd1;

      check("p0_gnt", p0_gnt, e_g0);
      check("p1_gnt", p1_gnt, e_g1);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_we", mem_we, e_we);
      check("p0_rvalid", p0_rvalid, e_rv0);
      check("p1_rvalid", p1_rvalid, e_rv1);
      check("p0_rdata", p0_rdata, e_rd0);
      check("p1_rdata", p1_rdata, e_rd1);
      check("addr_err", addr_err, m_err);

      if (head) void'(pend.pop_front());
      m_rd0 = e_rd0;
      m_rd1 = e_rd1;
      if ((e_g0 || e_g1) && e_addr >= RAM_WORDS) m_err = 1;
      if (e_g0 || (e_g1 && !p1_we)) begin
        d = (e_addr < RAM_WORDS) ? mdl_mem[e_addr] : 8'h00;
        pend.push_back('{cyc + READ_LAT, e_g1, d});
      end
      if (e_we) mdl_mem[e_addr] = p1_wdata;
      m_starve = (run && p1_req && !e_g1) ? ((m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT) : 0;
      m_addr  = e_addr;
      m_wdata = e_wd;
      if (init_done) m_run = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int  p1_cnt, first_p1, exp_idx;
    bit  g0;
    reset = 1; init_done = 0;
    p0_req = 1; p0_addr = '0;
    p1_req = 1; p1_we = 0; p1_addr = 19'd100; p1_wdata = '0;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_addr_err", addr_err, 0);

    for (int c = 0; c < 100; c++) begin
      tick(); #1;
      check("init_wait_gnt", {p0_gnt, p1_gnt, mem_we}, 3'b000);
    end

    // Both ports reading continuously: engine wins once per 16 cycles.
    init_done = 1;
    #1;
    check("init_p0_gnt", p0_gnt, 1);
    check("init_p1_gnt", p1_gnt, 0);
    p1_cnt = 0; first_p1 = -1; exp_idx = 0;
    for (int c = 0; c < 48; c++) begin
      if (p1_gnt) begin
        p1_cnt++;
        if (first_p1 < 0) first_p1 = c;
      end
      g0 = p0_gnt;
      if (p0_rvalid) begin
        check("p0_rom_data", p0_rdata, rom_byte(exp_idx));
        exp_idx++;
      end
      tick();
      if (g0) p0_addr = p0_addr + 1'b1;
      #1;
    end
    check("p1_grant_count", p1_cnt, 3);
    check("p1_first_grant", first_p1, 15);
    check("p0_resp_count", exp_idx, 44);
    p0_req = 0; p1_req = 0;
    tick(); tick(); tick();

    // Engine write then read-back.
    p1_req = 1; p1_we = 1; p1_addr = 19'h00010; p1_wdata = 8'hA5;
    #1;
    check("wr_gnt", p1_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 19'h00010);
    check("wr_mem_wdata", mem_wdata, 8'hA5);
    tick();
    p1_we = 0;
    #1;
    check("rd_gnt", p1_gnt, 1);
    check("rd_mem_we", mem_we, 0);
    tick();
    p1_req = 0;
    #1;
    check("rd_lat1_rvalid", p1_rvalid, 0);
    tick(); #1;
    check("rd_lat2_rvalid", p1_rvalid, 1);
    check("rd_lat2_rdata", p1_rdata, 8'hA5);
    tick(); #1;
    check("rd_after_rvalid", p1_rvalid, 0);
    check("rd_hold_rdata", p1_rdata, 8'hA5);

    // Alternating single-port reads.
    p0_addr = 19'd5; p1_addr = 19'h00010; p1_we = 0;
    for (int i = 0; i < 8; i++) begin
      p0_req = (i < 6) && (i % 2 == 0);
      p1_req = (i < 6) && (i % 2 == 1);
      #1;
      if (i < 6) check("alt_gnt", (i % 2 == 0) ? p0_gnt : p1_gnt, 1);
      if (i >= 2) begin
        if ((i - 2) % 2 == 0) begin
          check("alt_p0_rvalid", {p0_rvalid, p1_rvalid}, 2'b10);
          check("alt_p0_rdata", p0_rdata, 8'h39);
        end else begin
          check("alt_p1_rvalid", {p0_rvalid, p1_rvalid}, 2'b01);
          check("alt_p1_rdata", p1_rdata, 8'hA5);
        end
      end
      tick();
    end

    // Out-of-range write and read.
    p1_req = 1; p1_we = 1; p1_addr = 19'd307200; p1_wdata = 8'h5A;
    #1;
    check("oor_wr_gnt", p1_gnt, 1);
    check("oor_wr_mem_we", mem_we, 0);
    check("oor_err_before", addr_err, 0);
    tick();
    p1_we = 0; p1_addr = 19'd307205;
    #1;
    check("oor_err_set", addr_err, 1);
    check("oor_rd_gnt", p1_gnt, 1);
    tick();
    p1_req = 0;
    tick(); #1;
    check("oor_rd_rvalid", p1_rvalid, 1);
    check("oor_rd_rdata", p1_rdata, 8'h00);
    tick(); tick(); tick(); #1;
    check("oor_err_sticky", addr_err, 1);

    // Reset one cycle after a read grant.
    p1_req = 1; p1_addr = 19'h00010; p1_we = 0;
    #1;
    check("rst_rd_gnt", p1_gnt, 1);
    tick();
    reset = 1; init_done = 0; p1_req = 0; p0_req = 1;
    tick();
    reset = 0;
    #1;
    check("flush_p1_rvalid", p1_rvalid, 0);
    check("flush_p0_gnt", p0_gnt, 0);
    check("flush_addr_err", addr_err, 0);
    check("flush_p1_rdata", p1_rdata, 0);
    tick(); #1;
    check("flush_p1_rvalid2", p1_rvalid, 0);
    check("flush_wait_init", p0_gnt, 0);
    init_done = 1;
    #1;
    check("reinit_p0_gnt", p0_gnt, 1);
    tick();
    p0_req = 0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single external RAM port of the frame-memory block (640x480 = 307200 bytes, 19-bit address, 8-bit data) between two requesters.
  - Port 0 is the display scanner: read-only, fixed priority.
  - Port 1 is the image-processing engine: read/write.
- Blocks all access until the memory block reports that its ROM->RAM initialisation copy is complete.
- Tracks in-flight reads so each read response is returned to the requester that issued it.
- Sits between the VGA/processing logic and the memory block's RAM interface.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 8, RAM data width.
- RAM_WORDS, 307200, number of valid RAM addresses.
- READ_LAT, 2, cycles from grant to RAM data on mem_q; also the depth of the tag pipeline.
- MAX_WAIT, 15, consecutive denied cycles of port 1 before it is forced ahead of port 0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- init_done  in  1  memory block has finished its initialisation copy
- p0_req  in  1  display read request
- p0_addr  in  ADDR_W  display read address
- p0_gnt  out  1  p0 request accepted this cycle
- p0_rvalid  out  1  p0 read data valid
- p0_rdata  out  DATA_W  p0 read data
- p1_req  in  1  engine request
- p1_we  in  1  1 = write, 0 = read
- p1_addr  in  ADDR_W  engine address
- p1_wdata  in  DATA_W  engine write data
- p1_gnt  out  1  p1 request accepted this cycle
- p1_rvalid  out  1  p1 read data valid
- p1_rdata  out  DATA_W  p1 read data
- mem_addr  out  ADDR_W  to memory block ram_address
- mem_wdata  out  DATA_W  to memory block ram_data_in
- mem_we  out  1  to memory block wren_in
- mem_q  in  DATA_W  from memory block q_out_ram
- addr_err  out  1  sticky: an out-of-range address was accepted

Behaviour:
- States:
  - WAIT_INIT (reset state): no grants are issued.
  - The arbiter moves to RUN on the first cycle init_done=1.
  - RUN is left only on reset.
- Grant is combinational, in the same cycle as the request; gnt=1 means the request is consumed on that clock edge.
- Priority in RUN:
  - p0 wins by default.
  - When starve_cnt==MAX_WAIT, p1 wins if p1_req is asserted.
  - At most one grant per cycle.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) when p1_req=1 and p1_gnt=0.
  - Clears on p1_gnt or when p1_req=0.
- mem_addr, mem_wdata and mem_we are driven combinationally from the granted port.
  - p0 grant: mem_we=0.
  - No grant: mem_we=0; mem_addr and mem_wdata hold their previous values (registered copies are kept).
- Out-of-range address (addr >= RAM_WORDS):
  - The request is granted; mem_we is forced to 0; addr_err sets and stays set until reset.
  - A read still produces rvalid, with rdata = 0.
- Read tagging:
  - A shift register of depth READ_LAT carries {valid, port, zero} for each granted read.
  - With a grant in cycle N, pX_rvalid is high in cycle N+READ_LAT and pX_rdata equals mem_q in that cycle, or 0 if zero=1.
  - Writes produce no rvalid.
  - Back-to-back reads sustain one response per cycle.
- rdata of the port whose rvalid is low holds its last value.
- Reset mid-operation: the tag pipeline is flushed (no rvalid after reset), starve_cnt=0, state=WAIT_INIT.
- Reset values: p0_gnt=0, p1_gnt=0, p0_rvalid=0, p1_rvalid=0, p0_rdata=0, p1_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, addr_err=0.
- init_done falling to 0 while in RUN is ignored.

Decomposition:
- Shared package holds: ADDR_W, DATA_W, RAM_WORDS, the ROM_WORDS=76800 constant, and the tag struct {valid, port, zero}.
- One sub-module: rd_tag_pipe, a READ_LAT-deep shift register of tags with a synchronous flush.

Test Plan:
- Reset with init_done=0 held for 100 cycles while p0_req=p1_req=1 -> no gnt and mem_we=0 throughout. Then raise init_done -> p0_gnt=1 on the same cycle.
- Engine writes 0xA5 to address 0x00010, then reads the same address -> p1_rvalid exactly 2 cycles after the read grant, with p1_rdata=0xA5.
- p0 and p1 both requesting reads continuously -> p1_gnt occurs once every 16 cycles (after 15 denials). Responses are routed by tag with no swaps: p0 addresses 0..N return ROM-copied bytes on p0_rdata only.
- Alternating p0 and p1 reads on consecutive cycles -> rvalid alternates p0/p1 on consecutive cycles with correct data and no lost responses.
- p1 write to address 307200 -> mem_we=0, addr_err=1 and stays 1. A p1 read of address 307205 -> p1_rvalid with p1_rdata=0x00.
- Assert reset one cycle after a read grant -> no rvalid follows, and the arbiter returns to WAIT_INIT.
